// File: rtl/fpu_exc_unit.sv
// fpu_exc_unit
//   Floating-point result classifier and exception accumulator. It sits between
//   the FP ALU write-back stage and the CSR file. A single valid/ready register
//   stage holds each result together with its one-hot fclass vector.
//   Exception hints from the datapath are merged into sticky fflags and counted.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = !out_valid | out_ready)
//   Result, exc_hint      FPU result {sign,exp,mantissa} and flags {NV,DZ,OF,UF,NX}
//   out_valid / out_ready output handshake
//   out_result, out_class registered result and 10-bit fclass vector
//   fflags                sticky accrued flags {NV,DZ,OF,UF,NX}
//   csr_we, csr_wdata     CSR write of fflags
//   cnt_clr, exc_cnt      clear / saturating count of flag-raising results
//   exc_pulse             one-cycle strobe for results raising a trapped flag
module fpu_exc_unit #(
    parameter int         EXP       = 8,
    parameter int         MANTISSA  = 23,
    parameter int         FLEN      = EXP + MANTISSA + 1,
    parameter int         CNT_W     = 16,
    parameter logic [4:0] TRAP_MASK = 5'b11000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLEN-1:0]  Result,
    input  logic [4:0]       exc_hint,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_result,
    output logic [9:0]       out_class,
    output logic [4:0]       fflags,
    input  logic             csr_we,
    input  logic [4:0]       csr_wdata,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] exc_cnt,
    output logic             exc_pulse
);

    logic                sign;
    logic [EXP-1:0]      exp_f;
    logic [MANTISSA-1:0] man_f;
    logic                exp_ones;
    logic                exp_zero;
    logic                man_zero;
    logic                is_snan;
    logic [9:0]          cls;
    logic [4:0]          new_flags;
    logic                accept;
    logic                flagged;

    assign sign     = Result[FLEN-1];
    assign exp_f    = Result[FLEN-2 -: EXP];
    assign man_f    = Result[MANTISSA-1:0];
    assign exp_ones = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;
    // A NaN with the top fraction bit clear is signalling.
    assign is_snan  = exp_ones & ~man_zero & ~man_f[MANTISSA-1];

    always_comb begin
        cls = '0;
        if (exp_ones) begin
            if (!man_zero) begin
                if (man_f[MANTISSA-1]) cls[9] = 1'b1;
                else                   cls[8] = 1'b1;
            end else if (sign) begin
                cls[0] = 1'b1;
            end else begin
                cls[7] = 1'b1;
            end
        end else if (exp_zero) begin
            if (man_zero) begin
                if (sign) cls[3] = 1'b1;
                else      cls[4] = 1'b1;
            end else begin
                if (sign) cls[2] = 1'b1;
                else      cls[5] = 1'b1;
            end
        end else begin
            if (sign) cls[1] = 1'b1;
            else      cls[6] = 1'b1;
        end
    end

    // Overflow and underflow always imply an inexact result.
    assign new_flags[4] = exc_hint[4] | is_snan;
    assign new_flags[3] = exc_hint[3];
    assign new_flags[2] = exc_hint[2];
    assign new_flags[1] = exc_hint[1];
    assign new_flags[0] = exc_hint[0] | exc_hint[2] | exc_hint[1];

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign flagged  = accept & (|new_flags);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_class  <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= Result;
            out_class  <= cls;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // A CSR write merges with a same-cycle exception so nothing is lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fflags <= '0;
        end else if (csr_we) begin
            fflags <= csr_wdata | (accept ? new_flags : 5'b00000);
        end else if (accept) begin
            fflags <= fflags | new_flags;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exc_cnt <= '0;
        end else if (cnt_clr) begin
            exc_cnt <= '0;
        end else if (flagged && (exc_cnt != {CNT_W{1'b1}})) begin
            exc_cnt <= exc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exc_pulse <= 1'b0;
        end else begin
            exc_pulse <= accept & (|(new_flags & TRAP_MASK));
        end
    end

endmodule

// File: doc/fpu_exc_unit.md
Name: fpu_exc_unit

Overview:
- Parametrised successor to the FPU result-error detector.
- Classifies every FPU result into the full 10-bit RISC-V fclass vector, including sNaN/qNaN split, ±0 and ±subnormal.
- Merges datapath exception hints into sticky fflags (NV DZ OF UF NX) and counts exception-raising results.
- Sits between the floating ALU write-back stage and the CSR file, behind a one-deep valid/ready register stage.

Parameters:
- EXP, 8, exponent field width.
- MANTISSA, 23, fraction field width.
- FLEN, EXP+MANTISSA+1, total operand width.
- CNT_W, 16, width of the exception event counter.
- TRAP_MASK, 5'b11000, fflags bits that raise exc_pulse (default NV, DZ).

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-high reset.
- in_valid  input  1  result presented.
- in_ready  output  1  stage can accept.
- Result  input  FLEN  {sign, exp, mantissa} from FPU.
- exc_hint  input  5  datapath flags {NV,DZ,OF,UF,NX}.
- out_valid  output  1  registered result valid.
- out_ready  input  1  consumer accepts.
- out_result  output  FLEN  registered Result.
- out_class  output  10  registered fclass vector (one-hot).
- fflags  output  5  sticky accrued flags.
- csr_we  input  1  load fflags from csr_wdata.
- csr_wdata  input  5  CSR write data.
- cnt_clr  input  1  clear exc_cnt.
- exc_cnt  output  CNT_W  saturating count of results with new_flags != 0.
- exc_pulse  output  1  one-cycle strobe when (new_flags & TRAP_MASK) != 0.

Behaviour:
- Reset (async, RST=1): out_valid=0, out_result=0, out_class=0, fflags=0, exc_cnt=0, exc_pulse=0. Any in-flight result is discarded. in_ready=1 while out_valid=0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - accept = in_valid & in_ready.
  - On accept, out_result/out_class load and out_valid=1 next edge.
  - If out_valid & out_ready & !in_valid, out_valid clears.
  - out_* are held stable while out_valid & !out_ready.
  - Latency is 1 cycle; throughput is 1/cycle with out_ready=1.
- Classification, with exp/man being the EXP/MANTISSA fields and sign=Result[FLEN-1]:
  - exp all-ones, man!=0: qNaN (bit9) if man[MANTISSA-1]=1, else sNaN (bit8). Sign is ignored.
  - exp all-ones, man==0: -inf bit0 / +inf bit7.
  - exp==0, man==0: -0 bit3 / +0 bit4.
  - exp==0, man!=0: -subnormal bit2 / +subnormal bit5.
  - Otherwise: -normal bit1 / +normal bit6.
  - All compares are width-generic; no literal 8'hFF.
- new_flags (combinational from the input side):
  - NV = exc_hint[4] | input is sNaN.
  - DZ = exc_hint[3].
  - OF = exc_hint[2].
  - UF = exc_hint[1].
  - NX = exc_hint[0] | OF | UF.
- fflags update per edge, in priority order:
  - csr_we: fflags <= csr_wdata | (accept ? new_flags : 0). A write never loses a same-cycle exception.
  - else accept: fflags <= fflags | new_flags.
  - else hold.
  - fflags is visible the cycle after the update.
- exc_cnt:
  - cnt_clr has priority: exc_cnt <= 0, and an accept in the same cycle is NOT counted.
  - else accept & new_flags!=0: increment, saturating at all-ones (no wrap).
- exc_pulse is registered: 1 for exactly one cycle after an accept with (new_flags & TRAP_MASK)!=0, otherwise 0. Back-to-back qualifying accepts keep it high on consecutive cycles.
- No flags or count are generated when in_valid=1 and in_ready=0; the input must be held by the source.

Test Plan:
- Classes at FLEN=32, each with out_ready=1:
  - 0x7F800000 -> out_class=0x080.
  - 0xFF800000 -> 0x001.
  - 0x80000000 -> 0x008.
  - 0x00000001 -> 0x020.
  - 0x3F800000 -> 0x040.
  - 0x7FC00000 -> 0x200.
  - fflags stays 0, exc_cnt stays 0.
- sNaN 0x7FA00000, exc_hint=0 -> out_class=0x100, fflags=0x10 next cycle, exc_cnt=1, exc_pulse high for 1 cycle.
- Backpressure: out_ready=0, two results offered:
  - Second sees in_ready=0 and is not consumed; out_result holds the first.
  - Raising out_ready accepts the second the same cycle; out_valid stays 1.
- exc_hint=5'b00100 with csr_we=1, csr_wdata=5'b00010 in the same accept cycle -> fflags=5'b00111 (OF forces NX). cnt_clr with a simultaneous flagged accept -> exc_cnt=0.
- CNT_W=2: five flagged accepts -> exc_cnt goes 1, 2, 3, 3, 3.
- Assert RST mid-transfer with out_valid=1, fflags=0x1F -> all outputs 0 immediately, without waiting for CLK; in_ready=1 after release.
